// File: rtl/demux_pkg.sv
// ---------------------------------------------------------------------------
// demux_pkg
// Shared constants and types for the 1-to-2 stream demultiplexer slice.
//   DATA_W     : width of a stream word
//   FIFO_DEPTH : entries per output FIFO (power of two, >= 2)
//   CNT_W      : width of the per-port delivery counters (wrap modulo 2**CNT_W)
//   word_t     : one stream word
// ---------------------------------------------------------------------------
package demux_pkg;
    localparam int DATA_W     = 3;
    localparam int FIFO_DEPTH = 2;
    localparam int CNT_W      = 8;

    typedef logic [DATA_W-1:0] word_t;
endpackage

// File: rtl/demux2_stream_if.sv
// ---------------------------------------------------------------------------
// demux2_stream_if
// Bundles the input stream, both output streams and the delivery counters.
//   in_data/in_sel/in_valid -> in_ready       : source side handshake
//   outk_data/outk_valid    -> outk_ready     : consumer k handshake
//   cnt0/cnt1                                 : words delivered per port
// modport master : the environment (source and both consumers)
// modport slave  : the demultiplexer itself
// ---------------------------------------------------------------------------
interface demux2_stream_if
    import demux_pkg::*;
#(
    parameter int W = DATA_W
);
    logic [W-1:0]     in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     out0_data;
    logic             out0_valid;
    logic             out0_ready;
    logic [W-1:0]     out1_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [CNT_W-1:0] cnt0;
    logic [CNT_W-1:0] cnt1;

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
    );
endinterface

// File: rtl/fifo_sync.sv
// ---------------------------------------------------------------------------
// fifo_sync
// Small synchronous FIFO with a valid/ready read side and a delivery counter.
//   clk, rst   : clock, synchronous active-high reset (clears storage too)
//   push       : write push_data this cycle (caller guarantees !full)
//   push_data  : word to write
//   pop_ready  : consumer takes the head word when out_valid is high
//   out_data   : head word (memory at read pointer; stale when empty)
//   out_valid  : FIFO non-empty
//   full       : occupancy equals DEPTH
//   cnt        : number of words popped, wraps naturally
// ---------------------------------------------------------------------------
module fifo_sync #(
    parameter int W     = 3,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop_ready,
    output logic [W-1:0]     out_data,
    output logic             out_valid,
    output logic             full,
    output logic [CNT_W-1:0] cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;   // occupancy kept apart from the pointers so full/empty are unambiguous
    logic          pop;

    assign out_valid = (count != '0);
    assign full      = (count == FULL_CNT);
    assign pop       = out_valid && pop_ready;
    assign out_data  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/demux2_stream.sv
// ---------------------------------------------------------------------------
// demux2_stream
// Registered 1-to-2 stream demultiplexer. Each input word is steered by
// in_sel into one of two independent FIFOs; each FIFO drains at its own pace.
//   clk, rst : clock, synchronous active-high reset
//   bus      : demux2_stream_if.slave (input stream, two output streams,
//              per-port delivery counters)
// in_ready reflects only the selected FIFO's fullness, so a word aimed at a
// full port stalls the source until either that port drains or the source
// changes its select.
// ---------------------------------------------------------------------------
module demux2_stream
    import demux_pkg::*;
#(
    parameter int W     = DATA_W,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic           clk,
    input  logic           rst,
    demux2_stream_if.slave bus
);
    logic full0;
    logic full1;
    logic accept;
    logic push0;
    logic push1;

    // No bypass: a full FIFO refuses even if it is being popped this cycle.
    assign bus.in_ready = !rst && !(bus.in_sel ? full1 : full0);
    assign accept       = bus.in_valid && bus.in_ready;
    assign push0        = accept && !bus.in_sel;
    assign push1        = accept &&  bus.in_sel;

    fifo_sync #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (bus.in_data),
        .pop_ready (bus.out0_ready),
        .out_data  (bus.out0_data),
        .out_valid (bus.out0_valid),
        .full      (full0),
        .cnt       (bus.cnt0)
    );

    fifo_sync #(
        .W     (W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (bus.in_data),
        .pop_ready (bus.out1_ready),
        .out_data  (bus.out1_data),
        .out_valid (bus.out1_valid),
        .full      (full1),
        .cnt       (bus.cnt1)
    );
endmodule

// File: tb/tb_demux2_stream.sv
// ---------------------------------------------------------------------------
// tb_demux2_stream
// Directed and random stimulus for demux2_stream. A queue-per-port model
// predicts in_ready, valids, head data and delivery counts every cycle.
// ---------------------------------------------------------------------------
module tb_demux2_stream;
    import demux_pkg::*;

    localparam int DEPTH = FIFO_DEPTH;

    logic clk = 1'b0;
    logic rst;

    demux2_stream_if #(.W(DATA_W)) bus ();

    demux2_stream #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    word_t q0[$];
    word_t q1[$];
    int    c0    = 0;
    int    c1    = 0;
    bit    known = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check model predictions, advance model at posedge.
    task automatic step(input logic r, input logic v, input logic s, input word_t d,
                        input logic rd0, input logic rd1);
        bit acc;
        bit p0;
        bit p1;
        @(negedge clk);
        rst            = r;
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = rd0;
        bus.out1_ready = rd1;
        #1;
        chk("in_ready", bus.in_ready,
            (!r && ((s ? q1.size() : q0.size()) < DEPTH)) ? 32'd1 : 32'd0);
        if (known) begin
            chk("out0_valid", bus.out0_valid, (q0.size() != 0) ? 32'd1 : 32'd0);
            chk("out1_valid", bus.out1_valid, (q1.size() != 0) ? 32'd1 : 32'd0);
            if (q0.size() != 0) chk("out0_data", bus.out0_data, q0[0]);
            if (q1.size() != 0) chk("out1_data", bus.out1_data, q1[0]);
            chk("cnt0", bus.cnt0, c0);
            chk("cnt1", bus.cnt1, c1);
        end
        @(posedge clk);
        if (r) begin
            q0.delete();
            q1.delete();
            c0    = 0;
            c1    = 0;
            known = 1;
        end else begin
            acc = v && ((s ? q1.size() : q0.size()) < DEPTH);
            p0  = rd0 && (q0.size() != 0);
            p1  = rd1 && (q1.size() != 0);
            if (p0) begin void'(q0.pop_front()); c0 = (c0 + 1) % 256; end
            if (p1) begin void'(q1.pop_front()); c1 = (c1 + 1) % 256; end
            if (acc) begin
                if (s) q1.push_back(d);
                else   q0.push_back(d);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sel = 1'b0; bus.in_data = '0;
        bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;

        // Reset, then idle
        step(1, 0, 0, 3'b000, 0, 0);
        step(1, 0, 0, 3'b000, 0, 0);
        #1;
        chk("rst_out0_valid", bus.out0_valid, 0);
        chk("rst_out1_valid", bus.out1_valid, 0);
        chk("rst_cnt0", bus.cnt0, 0);
        chk("rst_cnt1", bus.cnt1, 0);
        chk("rst_out0_data", bus.out0_data, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        step(0, 0, 0, 3'b000, 0, 0);
        #1;
        chk("idle_in_ready", bus.in_ready, 1);

        // Single route to port 0
        step(0, 1, 0, 3'b101, 1, 0);
        #1;
        chk("route_out0_valid", bus.out0_valid, 1);
        chk("route_out0_data", bus.out0_data, 3'b101);
        chk("route_out1_valid", bus.out1_valid, 0);
        step(0, 0, 0, 3'b000, 1, 0);
        #1;
        chk("route_out0_empty", bus.out0_valid, 0);
        chk("route_cnt0", bus.cnt0, 1);

        // Backpressure on port 1
        step(0, 1, 1, 3'b001, 0, 0);
        step(0, 1, 1, 3'b010, 0, 0);
        #1;
        chk("bp_full_ready", bus.in_ready, 0);
        step(0, 1, 1, 3'b011, 0, 0);

        // Head-of-line: switch select to the free port
        step(0, 1, 0, 3'b110, 0, 0);
        #1;
        chk("hol_out0_valid", bus.out0_valid, 1);
        chk("hol_out0_data", bus.out0_data, 3'b110);
        step(0, 0, 0, 3'b000, 1, 0);

        // Drain port 1 while retrying the stalled word
        step(0, 1, 1, 3'b011, 0, 1);
        #1;
        chk("bp_ready_back", bus.in_ready, 1);
        chk("bp_head_010", bus.out1_data, 3'b010);
        step(0, 1, 1, 3'b011, 0, 1);
        #1;
        chk("bp_head_011", bus.out1_data, 3'b011);
        chk("bp_out1_valid", bus.out1_valid, 1);
        step(0, 0, 0, 3'b000, 0, 1);
        #1;
        chk("bp_cnt1", bus.cnt1, 3);
        chk("bp_out1_empty", bus.out1_valid, 0);

        // Simultaneous push and pop on port 0
        step(0, 1, 0, 3'b010, 0, 0);
        step(0, 1, 0, 3'b111, 1, 0);
        #1;
        chk("pp_out0_valid", bus.out0_valid, 1);
        chk("pp_out0_data", bus.out0_data, 3'b111);
        chk("pp_cnt0", bus.cnt0, 3);
        step(0, 0, 0, 3'b000, 1, 0);
        #1;
        chk("pp_out0_empty", bus.out0_valid, 0);
        chk("pp_cnt0_after", bus.cnt0, 4);

        // Counter wrap: 257 words through port 0 from a fresh reset
        step(1, 0, 0, 3'b000, 0, 0);
        for (int i = 0; i < 257; i++) begin
            step(0, 1, 0, word_t'($urandom_range(7)), 1, 0);
        end
        step(0, 0, 0, 3'b000, 1, 0);
        #1;
        chk("wrap_cnt0", bus.cnt0, 1);

        // Mid-stream reset with words buffered on both ports
        step(0, 1, 0, 3'b100, 0, 0);
        step(0, 1, 1, 3'b101, 0, 0);
        step(1, 1, 0, 3'b111, 1, 1);
        #1;
        chk("mrst_out0_valid", bus.out0_valid, 0);
        chk("mrst_out1_valid", bus.out1_valid, 0);
        chk("mrst_cnt0", bus.cnt0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 3'b000, 1, 1);
        end

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(49) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 word_t'($urandom_range(7)), 1'($urandom_range(1)), 1'($urandom_range(1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
